// File: rtl/vc_injection_arbiter.sv
// Wormhole injection arbiter: round-robin packet grant among VC sources onto one
// router local port, holding the grant from head flit through tail flit.
module vc_injection_arbiter #(
   parameter int VC              = 4,
   parameter int DATA_WIDTH      = 32,
   parameter int IDENTIFIER_BITS = 2,
   localparam int VW             = $clog2(VC)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [VC*DATA_WIDTH-1:0] data_in,
   input  logic [VC-1:0]            valid_in,
   output logic [VC-1:0]            ready_in,
   output logic [DATA_WIDTH-1:0]    data_out,
   output logic                     valid_out,
   input  logic                     ready_out,
   output logic [VW-1:0]            vc_out,
   output logic                     busy,
   output logic [31:0]              packets_sent,
   output logic                     protocol_error
);

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   localparam logic [IDENTIFIER_BITS-1:0] KIND_HEAD = IDENTIFIER_BITS'(2'b01);
   localparam logic [IDENTIFIER_BITS-1:0] KIND_TAIL = IDENTIFIER_BITS'(2'b11);

   function automatic logic [IDENTIFIER_BITS-1:0] flit_kind(input logic [DATA_WIDTH-1:0] flit);
      return flit[DATA_WIDTH-1 -: IDENTIFIER_BITS];
   endfunction

   logic [DATA_WIDTH-1:0]      flit_s [VC];
   logic [VC-1:0]              head_s;
   state_t                     state_r, state_next_s;
   logic [VW-1:0]              ptr_r, ptr_next_s;
   logic [VW-1:0]              lock_vc_r, lock_vc_next_s;
   logic                       head_done_r, head_done_next_s;
   logic [31:0]                packets_sent_r, packets_next_s;
   logic                       protocol_error_r, error_next_s;
   logic                       grant_found_s;
   logic [VW-1:0]              grant_vc_s;
   logic [VW-1:0]              idx_s;
   logic                       xfer_s;
   logic [IDENTIFIER_BITS-1:0] lock_kind_s;

   // Unpack per-VC flits and classify head flits
   always_comb begin
      for (int i = 0; i < VC; i++) begin
         flit_s[i] = data_in[i*DATA_WIDTH +: DATA_WIDTH];
         head_s[i] = (flit_kind(flit_s[i]) == KIND_HEAD);
      end
   end

   // Round-robin search for the first valid head starting at ptr
   always_comb begin
      grant_found_s = 1'b0;
      grant_vc_s    = ptr_r;
      idx_s         = ptr_r;
      for (int k = 0; k < VC; k++) begin
         idx_s = ptr_r + VW'(k);
         if (!grant_found_s && valid_in[idx_s] && head_s[idx_s]) begin
            grant_found_s = 1'b1;
            grant_vc_s    = idx_s;
         end else begin
            grant_vc_s = grant_vc_s;
         end
      end
   end

   // Combinational pass-through of the locked VC
   always_comb begin
      data_out  = {DATA_WIDTH{1'b0}};
      valid_out = 1'b0;
      ready_in  = {VC{1'b0}};
      if (state_r == LOCKED) begin
         data_out            = flit_s[lock_vc_r];
         valid_out           = valid_in[lock_vc_r];
         ready_in[lock_vc_r] = ready_out;
      end else begin
         data_out = {DATA_WIDTH{1'b0}};
      end
   end

   assign xfer_s         = (state_r == LOCKED) && valid_in[lock_vc_r] && ready_out;
   assign lock_kind_s    = flit_kind(flit_s[lock_vc_r]);
   assign vc_out         = lock_vc_r;
   assign busy           = (state_r == LOCKED);
   assign packets_sent   = packets_sent_r;
   assign protocol_error = protocol_error_r;

   // Next-state: grant in IDLE, release on tail, flag protocol violations
   always_comb begin
      state_next_s     = state_r;
      ptr_next_s       = ptr_r;
      lock_vc_next_s   = lock_vc_r;
      head_done_next_s = head_done_r;
      packets_next_s   = packets_sent_r;
      error_next_s     = protocol_error_r;
      case (state_r)
         IDLE: begin
            if (grant_found_s) begin
               state_next_s     = LOCKED;
               lock_vc_next_s   = grant_vc_s;
               head_done_next_s = 1'b0;
            end else begin
               state_next_s = IDLE;
            end
            if (|(valid_in & ~head_s)) begin
               error_next_s = 1'b1;
            end else begin
               error_next_s = protocol_error_r;
            end
         end
         LOCKED: begin
            if (xfer_s) begin
               head_done_next_s = 1'b1;
               if (lock_kind_s == KIND_TAIL) begin
                  state_next_s   = IDLE;
                  ptr_next_s     = lock_vc_r + VW'(1);
                  packets_next_s = packets_sent_r + 32'd1;
               end else if ((lock_kind_s == KIND_HEAD) && head_done_r) begin
                  // a second head inside one packet: pass it but remember the fault
                  error_next_s = 1'b1;
               end else begin
                  state_next_s = LOCKED;
               end
            end else begin
               state_next_s = LOCKED;
            end
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r          <= IDLE;
         ptr_r            <= {VW{1'b0}};
         lock_vc_r        <= {VW{1'b0}};
         head_done_r      <= 1'b0;
         packets_sent_r   <= 32'd0;
         protocol_error_r <= 1'b0;
      end else begin
         state_r          <= state_next_s;
         ptr_r            <= ptr_next_s;
         lock_vc_r        <= lock_vc_next_s;
         head_done_r      <= head_done_next_s;
         packets_sent_r   <= packets_next_s;
         protocol_error_r <= error_next_s;
      end
   end

endmodule
